load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: funct3 size/sign encodings,
// the access FSM state type and small decode helpers used both by the FSM
// (size, legality, split detection) and by the lane alignment logic.
// ---------------------------------------------------------------------------
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC0,
      ST_ACC1,
      ST_RESP
   } lsuState_e;

   // Access width in bytes. Illegal encodings report 4 so that the range
   // check still produces a sensible value; they are rejected anyway.
   function automatic logic [2:0] accessSize(input logic [2:0] funct3);
      logic [2:0] size;
      case (funct3[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         default: size = 3'd4;
      endcase
      return size;
   endfunction

   // Unsigned variants only make sense for loads.
   function automatic logic funct3Illegal(input logic [2:0] funct3, input logic we);
      logic bad;
      case (funct3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = we;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the load/store unit.
//   i_offset   : byte offset of the access inside its first word
//   i_funct3   : size/sign encoding of the access
//   i_wdata    : right-justified store data
//   i_loWord   : memory word read in the first access cycle
//   i_hiWord   : memory word read in the second access cycle (0 if none)
//   o_storeLo/o_storeHi : lane-aligned store data for first/second word
//   o_beLo/o_beHi       : byte enables for first/second word
//   o_loadData          : shifted and sign/zero extended load result
// ---------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_loWord,
   input  logic [31:0] i_hiWord,
   output logic [31:0] o_storeLo,
   output logic [31:0] o_storeHi,
   output logic [3:0]  o_beLo,
   output logic [3:0]  o_beHi,
   output logic [31:0] o_loadData
);

   logic [63:0] w_storeShift;
   logic [7:0]  w_sizeMask;
   logic [7:0]  w_maskShift;
   logic [63:0] w_loadShift;
   logic [31:0] w_loadWord;

   // Stores: treat the two touched words as one 64-bit window so an access
   // that straddles a word boundary simply spills its upper lanes into the
   // second word.
   always_comb begin
      w_storeShift = {32'd0, i_wdata} << {i_offset, 3'b000};
      case (accessSize(i_funct3))
         3'd1:    w_sizeMask = 8'b0000_0001;
         3'd2:    w_sizeMask = 8'b0000_0011;
         default: w_sizeMask = 8'b0000_1111;
      endcase
      w_maskShift = w_sizeMask << i_offset;
      o_storeLo   = w_storeShift[31:0];
      o_storeHi   = w_storeShift[63:32];
      o_beLo      = w_maskShift[3:0];
      o_beHi      = w_maskShift[7:4];
   end

   // Loads: the same 64-bit window shifted down, then extended by type.
   always_comb begin
      w_loadShift = {i_hiWord, i_loWord} >> {i_offset, 3'b000};
      w_loadWord  = w_loadShift[31:0];
      case (i_funct3)
         F3_B:    o_loadData = {{24{w_loadWord[7]}}, w_loadWord[7:0]};
         F3_H:    o_loadData = {{16{w_loadWord[15]}}, w_loadWord[15:0]};
         F3_BU:   o_loadData = {24'd0, w_loadWord[7:0]};
         F3_HU:   o_loadData = {16'd0, w_loadWord[15:0]};
         default: o_loadData = w_loadWord;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Turns one pipeline load/store request into one or two word accesses on a
// simple byte-enabled memory port and returns a single-cycle response.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only when idle)
//   req_we, req_funct3   : store/load and size/sign
//   req_addr, req_wdata  : byte address (any alignment), store data
//   resp_valid/rdata/err : one-cycle completion pulse with load data/error
//   mem_read/mem_write   : memory strobes, active in access cycles only
//   mem_addr/wdata/be    : word address, lane data and byte enables
//   mem_rdata            : combinational read word from memory
// ---------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata
);

   lsuState_e   r_state;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_split;
   logic        r_err;
   logic [31:0] r_loWord;
   logic [31:0] r_hiWord;

   logic [2:0]  w_reqSize;
   logic [32:0] w_reqLast;
   logic        w_reqErr;
   logic        w_reqSplit;
   logic [31:0] w_storeLo;
   logic [31:0] w_storeHi;
   logic [3:0]  w_beLo;
   logic [3:0]  w_beHi;
   logic [31:0] w_loadData;
   logic        w_inAcc;
   logic [31:0] w_wordAddr;

   // Decode the incoming request. The last-byte address is computed one bit
   // wider so that accesses near 0xFFFFFFFF cannot wrap back into range.
   always_comb begin
      w_reqSize  = accessSize(req_funct3);
      w_reqLast  = {1'b0, req_addr} + {30'd0, w_reqSize} - 33'd1;
      w_reqErr   = funct3Illegal(req_funct3, req_we) ||
                   (w_reqLast >= 33'(MEM_BYTES));
      w_reqSplit = ({2'b00, req_addr[1:0]} + {1'b0, w_reqSize}) > 4'd4;
   end

   // Access FSM. The high read word is cleared on acceptance so an aligned
   // load shifts in zeros above its single word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_we     <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_split  <= 1'b0;
         r_err    <= 1'b0;
         r_loWord <= 32'd0;
         r_hiWord <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_split  <= w_reqSplit;
                  r_err    <= w_reqErr;
                  r_loWord <= 32'd0;
                  r_hiWord <= 32'd0;
                  r_state  <= w_reqErr ? ST_RESP : ST_ACC0;
               end
            end
            ST_ACC0: begin
               r_loWord <= mem_rdata;
               r_state  <= r_split ? ST_ACC1 : ST_RESP;
            end
            ST_ACC1: begin
               r_hiWord <= mem_rdata;
               r_state  <= ST_RESP;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   lsu_align uAlign (
      .i_offset   (r_addr[1:0]),
      .i_funct3   (r_funct3),
      .i_wdata    (r_wdata),
      .i_loWord   (r_loWord),
      .i_hiWord   (r_hiWord),
      .o_storeLo  (w_storeLo),
      .o_storeHi  (w_storeHi),
      .o_beLo     (w_beLo),
      .o_beHi     (w_beHi),
      .o_loadData (w_loadData)
   );

   // Memory port decoded from the state. Strobes are masked by rst so that a
   // reset arriving during the second word abandons it before it commits.
   always_comb begin
      w_inAcc    = ((r_state == ST_ACC0) || (r_state == ST_ACC1)) && !rst;
      w_wordAddr = {r_addr[31:2], 2'b00};
      mem_read   = w_inAcc && !r_we;
      mem_write  = w_inAcc && r_we;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
      mem_be     = 4'd0;
      if (w_inAcc) begin
         if (r_state == ST_ACC0) begin
            mem_addr  = w_wordAddr;
            mem_wdata = w_storeLo;
            mem_be    = w_beLo;
         end else begin
            mem_addr  = w_wordAddr + 32'd4;
            mem_wdata = w_storeHi;
            mem_be    = w_beHi;
         end
      end
   end

   // Handshake and response; data is forced to zero outside a load response.
   always_comb begin
      req_ready  = (r_state == ST_IDLE);
      resp_valid = (r_state == ST_RESP);
      resp_err   = resp_valid && r_err;
      resp_rdata = (resp_valid && !r_err && !r_we) ? w_loadData : 32'd0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Drives directed load/store vectors through load_store_unit attached to a
// 1 KiB byte-array memory model, plus hand-written reset and handshake
// sequences.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;

   logic [7:0]  mem [0:1023];
   int          compared = 0;
   int          mismatched = 0;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
      int          expLat;
      logic [31:0] expAddr0;
      logic [31:0] expWdata0;
      logic [3:0]  expBe0;
      logic [31:0] expAddr1;
      logic [31:0] expWdata1;
      logic [3:0]  expBe1;
   } vec_t;

   vec_t vecs[$];

   load_store_unit #(.MEM_BYTES(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read of the addressed word, byte-enabled
   // write on the rising edge.
   assign mem_rdata = {mem[{mem_addr[9:2], 2'd3}], mem[{mem_addr[9:2], 2'd2}],
                       mem[{mem_addr[9:2], 2'd1}], mem[{mem_addr[9:2], 2'd0}]};

   always @(posedge clk) begin
      if (mem_write) begin
         for (int k = 0; k < 4; k++) begin
            if (mem_be[k]) mem[{mem_addr[9:2], 2'(k)}] = mem_wdata[8*k +: 8];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for an idle cycle, then leaves us at a negedge.
   task automatic waitReady(input string name);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, ".ready"}, 64'(req_ready), 64'd1);
   endtask

   task automatic applyStimulus(input vec_t v);
      int  strobes = 0;
      bit  seen = 0;
      waitReady(v.name);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (mem_read || mem_write) strobes++;
         if (c == 1 && !v.expErr) begin
            checkOutput({v.name, ".idleResp"}, {31'd0, resp_valid, resp_err, resp_rdata}, 64'd0);
            checkOutput({v.name, ".rw0"}, {62'd0, mem_read, mem_write}, {62'd0, !v.we, v.we});
            checkOutput({v.name, ".addr0"}, 64'(mem_addr), 64'(v.expAddr0));
            if (v.we) begin
               checkOutput({v.name, ".wdata0"}, 64'(mem_wdata), 64'(v.expWdata0));
               checkOutput({v.name, ".be0"}, 64'(mem_be), 64'(v.expBe0));
            end
         end
         if (c == 2 && v.expLat == 3) begin
            checkOutput({v.name, ".addr1"}, 64'(mem_addr), 64'(v.expAddr1));
            if (v.we) begin
               checkOutput({v.name, ".wdata1"}, 64'(mem_wdata), 64'(v.expWdata1));
               checkOutput({v.name, ".be1"}, 64'(mem_be), 64'(v.expBe1));
            end
         end
         if (resp_valid) begin
            seen = 1;
            checkOutput({v.name, ".latency"}, 64'(c), 64'(v.expLat));
            checkOutput({v.name, ".rdata"}, 64'(resp_rdata), 64'(v.expRdata));
            checkOutput({v.name, ".err"}, 64'(resp_err), 64'(v.expErr));
            break;
         end
         @(posedge clk);
         #1;
      end
      checkOutput({v.name, ".respSeen"}, 64'(seen), 64'd1);
      checkOutput({v.name, ".strobes"}, 64'(strobes), 64'(v.expLat - 1));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;

      // name, we, f3, addr, wdata, rdata, err, lat, a0, wd0, be0, a1, wd1, be1
      vecs.push_back('{"SW10",   1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        0, 2, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"LW10",   0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 0, 2, 32'h010, 32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"SB21",   1, 3'b000, 32'h021, 32'h80,       32'h0,        0, 2, 32'h020, 32'h00008000, 4'h2, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"LB21",   0, 3'b000, 32'h021, 32'h0,        32'hFFFFFF80, 0, 2, 32'h020, 32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"LBU21",  0, 3'b100, 32'h021, 32'h0,        32'h00000080, 0, 2, 32'h020, 32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"SW0E",   1, 3'b010, 32'h00E, 32'h11223344, 32'h0,        0, 3, 32'h00C, 32'h33440000, 4'hC, 32'h010, 32'h00001122, 4'h3});
      vecs.push_back('{"LW0E",   0, 3'b010, 32'h00E, 32'h0,        32'h11223344, 0, 3, 32'h00C, 32'h0,        4'h0, 32'h010, 32'h0,        4'h0});
      vecs.push_back('{"LH3FF",  0, 3'b001, 32'h3FF, 32'h0,        32'h0,        1, 1, 32'h0,   32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"F3011",  0, 3'b011, 32'h040, 32'h0,        32'h0,        1, 1, 32'h0,   32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"SBU",    1, 3'b100, 32'h040, 32'h55,       32'h0,        1, 1, 32'h0,   32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"SW3FE",  1, 3'b010, 32'h3FE, 32'h12345678, 32'h0,        1, 1, 32'h0,   32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"SH02",   1, 3'b001, 32'h002, 32'hF234,     32'h0,        0, 2, 32'h000, 32'hF2340000, 4'hC, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"LHU02",  0, 3'b101, 32'h002, 32'h0,        32'h0000F234, 0, 2, 32'h000, 32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"LH02",   0, 3'b001, 32'h002, 32'h0,        32'hFFFFF234, 0, 2, 32'h000, 32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"SW3FC",  1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        0, 2, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"LW3FC",  0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 0, 2, 32'h3FC, 32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"LB3FF",  0, 3'b000, 32'h3FF, 32'h0,        32'hFFFFFFCA, 0, 2, 32'h3FC, 32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"LH3FE",  0, 3'b001, 32'h3FE, 32'h0,        32'hFFFFCAFE, 0, 2, 32'h3FC, 32'h0,        4'h0, 32'h0,   32'h0,        4'h0});
      vecs.push_back('{"SH23",   1, 3'b001, 32'h023, 32'hA55A,     32'h0,        0, 3, 32'h020, 32'h5A000000, 4'h8, 32'h024, 32'h000000A5, 4'h1});
      vecs.push_back('{"LW21",   0, 3'b010, 32'h021, 32'h0,        32'hA55A0080, 0, 3, 32'h020, 32'h0,        4'h0, 32'h024, 32'h0,        4'h0});

      // Reset state: everything quiet, ready high.
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("reset.ready", 64'(req_ready), 64'd1);
      checkOutput("reset.resp", {31'd0, resp_valid, resp_err, resp_rdata}, 64'd0);
      checkOutput("reset.memCtl", {26'd0, mem_read, mem_write, mem_be}, 64'd0);
      checkOutput("reset.memBus", {mem_addr, mem_wdata}, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // Handshake: busy during the response cycle, ready the cycle after.
      checkOutput("b2b.readyInResp", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("b2b.readyAfterResp", 64'(req_ready), 64'd1);

      // Reset during the second word of a split store.
      mem[12'h1E] = 8'h11;
      mem[12'h1F] = 8'h22;
      mem[12'h20] = 8'h33;
      mem[12'h21] = 8'h44;
      waitReady("rstAcc1");
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h1E;
      req_wdata  = 32'hAABBCCDD;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstAcc1.inAcc1", {31'd0, mem_write, mem_addr}, {31'd0, 1'b1, 32'h20});
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rstAcc1.idle", {61'd0, req_ready, resp_valid, mem_write}, {61'd0, 1'b1, 1'b0, 1'b0});
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checkOutput("rstAcc1.noResp", 64'(resp_valid), 64'd0);
      end
      checkOutput("rstAcc1.lowBytes", {48'd0, mem[12'h1F], mem[12'h1E]}, 64'h0000_0000_0000_CCDD);
      checkOutput("rstAcc1.highBytes", {48'd0, mem[12'h21], mem[12'h20]}, 64'h0000_0000_0000_4433);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
